// File: rtl/ifetch_queue_pkg.sv
// Shared fetch-side definitions: reset PC, fetch FSM encoding and queue entry layout.
package ifetch_queue_pkg;

  localparam int          IFQ_AW       = 32;
  localparam logic [31:0] IFQ_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    IFQ_IDLE = 2'd0,
    IFQ_WAIT = 2'd1,
    IFQ_DROP = 2'd2
  } ifq_state_e;

  typedef struct packed {
    logic [31:0]        instr;
    logic [IFQ_AW-1:0]  pc;
  } ifq_entry_t;

  // Adds two counts without wrapping; sticks at all-ones.
  function automatic logic [31:0] sat_add32(logic [31:0] a, logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? '1 : sum[31:0];
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch bundle: PC/Bubble handshake, instruction-memory port and ID-stage queue head.
interface ifetch_queue_if #(
  parameter int AW = 32
);
  logic [AW-1:0] PC;
  logic          Bubble;
  logic          Flush;
  logic          Imem_Req;
  logic [AW-1:0] Imem_Addr;
  logic          Imem_Gnt;
  logic          Imem_Rvalid;
  logic [31:0]   Imem_Rdata;
  logic          ID_Valid;
  logic          ID_Ready;
  logic [31:0]   ID_Instr;
  logic [AW-1:0] ID_PC;

  modport master (
    input  PC, Flush, Imem_Gnt, Imem_Rvalid, Imem_Rdata, ID_Ready,
    output Bubble, Imem_Req, Imem_Addr, ID_Valid, ID_Instr, ID_PC
  );

  modport slave (
    output PC, Flush, Imem_Gnt, Imem_Rvalid, Imem_Rdata, ID_Ready,
    input  Bubble, Imem_Req, Imem_Addr, ID_Valid, ID_Instr, ID_PC
  );
endinterface

// File: rtl/ifetch_queue_fifo.sv
// ifq_fifo: DEPTH-entry synchronous FIFO with clear, occupancy count and combinational head.
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                       clk_i,
  input  logic                       srst_i,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic [W-1:0]               head_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          pop_en, push_en;

  assign pop_en  = pop_i && (count_q != '0);
  assign push_en = push_i && ((count_q != CW'(DEPTH)) || pop_en);

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk_i) begin
    if (srst_i || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_en && !pop_en)      count_q <= count_q + CW'(1);
      else if (pop_en && !push_en) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en && !srst_i && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: one outstanding imem request, credit-gated into a DEPTH FIFO.
// Optional IFETCH_PERF_CNT_EN adds saturating fetched/dropped/stall counters.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int            DEPTH    = 4,
  parameter int            AW       = IFQ_AW,
  parameter logic [AW-1:0] RESET_PC = AW'(IFQ_RESET_PC)
) (
  input  logic          Clk,
  input  logic          Reset,
`ifdef IFETCH_PERF_CNT_EN
  output logic [31:0]   Perf_Fetched,
  output logic [31:0]   Perf_Dropped,
  output logic [31:0]   Perf_Stall,
`endif
  ifetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH+1);

  ifq_state_e    state_q, state_d;
  logic [AW-1:0] req_pc_q, req_pc_d;
  logic          req, push, pop;
  logic [CW-1:0] count;
  logic          empty;
  ifq_entry_t    push_entry, head_entry;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IFQ_IDLE;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  // With at most one request in flight, count < DEPTH guarantees the response a slot.
  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    req      = 1'b0;
    push     = 1'b0;
    case (state_q)
      IFQ_IDLE: begin
        req = !Reset && !bus.Flush && (count < CW'(DEPTH));
        if (req && bus.Imem_Gnt) begin
          req_pc_d = bus.PC;
          state_d  = IFQ_WAIT;
        end
      end
      IFQ_WAIT: begin
        if (bus.Flush) begin
          state_d = bus.Imem_Rvalid ? IFQ_IDLE : IFQ_DROP;
        end else if (bus.Imem_Rvalid) begin
          push    = 1'b1;
          state_d = IFQ_IDLE;
        end
      end
      IFQ_DROP: begin
        if (bus.Imem_Rvalid) state_d = IFQ_IDLE;
      end
      default: state_d = IFQ_IDLE;
    endcase
  end

  assign pop = !bus.Flush && bus.ID_Ready && !empty;

  always_comb begin
    push_entry       = '0;
    push_entry.instr = bus.Imem_Rdata;
    push_entry.pc    = IFQ_AW'(req_pc_q);
  end

  ifq_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(ifq_entry_t))
  ) u_fifo (
    .clk_i   (Clk),
    .srst_i  (Reset),
    .clr_i   (bus.Flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_entry),
    .count_o (count),
    .empty_o (empty),
    .head_o  (head_entry)
  );

  assign bus.Imem_Req  = req;
  assign bus.Imem_Addr = bus.PC;
  assign bus.Bubble    = !(req && bus.Imem_Gnt);
  assign bus.ID_Valid  = !empty;
  assign bus.ID_Instr  = empty ? 32'h0 : head_entry.instr;
  assign bus.ID_PC     = empty ? RESET_PC : head_entry.pc[AW-1:0];

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetched_q, dropped_q, stall_q;
  logic [31:0] drop_amt;

  // A flush in WAIT loses the in-flight word too; DROP's word was already counted.
  assign drop_amt = bus.Flush ? (32'(count) + 32'(state_q == IFQ_WAIT)) : 32'h0;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fetched_q <= '0;
      dropped_q <= '0;
      stall_q   <= '0;
    end else begin
      fetched_q <= sat_add32(fetched_q, 32'(push));
      dropped_q <= sat_add32(dropped_q, drop_amt);
      stall_q   <= sat_add32(stall_q, 32'(bus.Bubble && !bus.Flush));
    end
  end

  assign Perf_Fetched = fetched_q;
  assign Perf_Dropped = dropped_q;
  assign Perf_Stall   = stall_q;
`endif
endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed phases then randomized traffic vs a queue model.
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifetch_queue_if #(.AW(AW)) bus ();

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_dropped, perf_stall;
`endif

  ifetch_queue #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .RESET_PC (32'h0000_3000)
  ) dut (
    .Clk          (clk),
    .Reset        (rst),
`ifdef IFETCH_PERF_CNT_EN
    .Perf_Fetched (perf_fetched),
    .Perf_Dropped (perf_dropped),
    .Perf_Stall   (perf_stall),
`endif
    .bus          (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        model_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] pc_m = 32'h3000;
  logic [31:0] out_addr = '0;
  logic [31:0] flush_target = 32'h3100;
  bit          outstanding = 0;
  bit          stale = 0;
  int          timer = 0;
  int          lat_cfg = 0;

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check at negedge+1, then advance the model for the coming edge.
  task automatic cycle(bit r_st, bit f, bit g, bit rdy, bit spur);
    bit   rv, ereq, acc;
    exp_t e;
    @(negedge clk);
    rst            = r_st;
    bus.Flush      = f;
    bus.Imem_Gnt   = g;
    bus.ID_Ready   = rdy;
    bus.PC         = pc_m;
    rv = outstanding && (timer == 0);
    if (rv) begin
      bus.Imem_Rvalid = 1'b1;
      bus.Imem_Rdata  = instr_of(out_addr);
    end else if (spur && !outstanding) begin
      bus.Imem_Rvalid = 1'b1;
      bus.Imem_Rdata  = $urandom;
    end else begin
      bus.Imem_Rvalid = 1'b0;
      bus.Imem_Rdata  = $urandom;
    end
    ereq = !r_st && !outstanding && !f && (model_q.size() < DEPTH);
    acc  = ereq && g;
    #1;
    if (!r_st) begin
      chk("imem_req",  64'(bus.Imem_Req),  64'(ereq));
      chk("bubble",    64'(bus.Bubble),    64'(!acc));
      chk("imem_addr", 64'(bus.Imem_Addr), 64'(pc_m));
      chk("id_valid",  64'(bus.ID_Valid),  64'(model_q.size() != 0));
      if (model_q.size() != 0) begin
        chk("id_pc",    64'(bus.ID_PC),    64'(model_q[0].pc));
        chk("id_instr", 64'(bus.ID_Instr), 64'(model_q[0].instr));
      end
    end
    if (r_st) begin
      model_q.delete();
      outstanding = 0;
      stale       = 0;
      pc_m        = 32'h3000;
    end else if (f) begin
      model_q.delete();
      if (outstanding) begin
        if (rv) begin
          outstanding = 0;
          stale       = 0;
        end else begin
          stale = 1;
          if (timer > 0) timer--;
        end
      end
      pc_m = flush_target;
    end else begin
      if (model_q.size() != 0 && rdy) e = model_q.pop_front();
      if (rv) begin
        if (!stale) model_q.push_back('{pc: out_addr, instr: instr_of(out_addr)});
        outstanding = 0;
        stale       = 0;
      end else if (outstanding && timer > 0) begin
        timer--;
      end
      if (acc) begin
        outstanding = 1;
        out_addr    = pc_m;
        timer       = lat_cfg;
        pc_m        = pc_m + 32'd4;
      end
    end
  endtask

  initial begin
    bus.Flush = 1'b0; bus.Imem_Gnt = 1'b0; bus.ID_Ready = 1'b0;
    bus.Imem_Rvalid = 1'b0; bus.Imem_Rdata = '0; bus.PC = 32'h3000;

    // Reset for two cycles, then release with no grant.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("reset_id_pc",    64'(bus.ID_PC),    64'h3000);
    chk("reset_id_instr", 64'(bus.ID_Instr), 64'h0);

    // Fill with zero-wait memory and no consumer.
    lat_cfg = 0;
    repeat (14) cycle(0, 0, 1, 0, 0);
    chk("fill_head_pc", 64'(bus.ID_PC), 64'h3000);

    // Concurrent push/pop across pointer wrap.
    repeat (24) cycle(0, 0, 1, 1, 0);

    // Flush while a request is in flight (response arrives later and must be dropped).
    lat_cfg = 2;
    for (int i = 0; i < 10 && !outstanding; i++) cycle(0, 0, 1, 1, 0);
    flush_target = 32'h3100;
    cycle(0, 1, 1, 0, 0);
    repeat (10) cycle(0, 0, 1, 0, 0);
    chk("after_flush_pc", 64'(bus.ID_PC), 64'h3100);

    // Flush coinciding with the response.
    lat_cfg = 0;
    repeat (6) cycle(0, 0, 1, 1, 0);
    for (int i = 0; i < 10 && !outstanding; i++) cycle(0, 0, 1, 1, 0);
    flush_target = 32'h3200;
    cycle(0, 1, 1, 1, 0);
    repeat (4) cycle(0, 0, 1, 0, 0);

    // Grant withheld for five cycles, then resumed.
    repeat (6) cycle(0, 0, 0, 1, 0);
    repeat (5) cycle(0, 0, 0, 0, 0);
    repeat (4) cycle(0, 0, 1, 1, 0);

    // Spurious responses while idle, and reset with a request in flight.
    repeat (3) cycle(0, 0, 0, 1, 1);
    lat_cfg = 3;
    for (int i = 0; i < 10 && !outstanding; i++) cycle(0, 0, 1, 1, 0);
    cycle(1, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 1);

    // Randomized traffic.
    repeat (800) begin
      lat_cfg      = $urandom_range(0, 3);
      flush_target = $urandom & 32'hFFFF_FFFC;
      cycle($urandom_range(0, 199) < 1, $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Fetch-side consumer of the PC register output.
- Each cycle it presents the current PC to the instruction memory as a request, waits for the response, and buffers fetched instructions in a small FIFO for the ID stage.
- It drives Bubble back to the PC register whenever the current PC was not accepted, so the PC holds.
- It discards queued and in-flight instructions on a pipeline flush (branch/jump redirect).

Parameters:
- DEPTH, 4: instruction queue entries; power of two, 2..16.
- AW, 32: address/PC width.
- RESET_PC, 32'h0000_3000: ID_PC value while the queue is empty after reset.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- PC  in  AW  current fetch address from the PC register.
- Bubble  out  1  1 = PC not consumed this cycle; PC register must hold.
- Flush  in  1  redirect; PC changes to the target on the next edge.
- Imem_Req  out  1  request valid.
- Imem_Addr  out  AW  request address (= PC).
- Imem_Gnt  in  1  memory accepts the request this cycle.
- Imem_Rvalid  in  1  response data valid.
- Imem_Rdata  in  32  instruction word.
- ID_Valid  out  1  queue head valid.
- ID_Ready  in  1  ID stage consumes the head this cycle.
- ID_Instr  out  32  head instruction.
- ID_PC  out  AW  address of the head instruction.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high. All state updates on posedge Clk.
- Reset values:
  - State = IDLE, count = 0, read/write pointers = 0.
  - ID_Valid = 0, ID_Instr = 0, ID_PC = RESET_PC.
  - Imem_Req = 0, Bubble = 1.
- FSM states: IDLE, WAIT, DROP.
  - IDLE: Imem_Req = 1 iff count + 0 < DEPTH and Flush = 0. On Req & Gnt, latch PC into req_pc and go to WAIT.
  - WAIT: Imem_Req = 0. On Rvalid, write {Rdata, req_pc} into the queue and go to IDLE. A new request is issued only from IDLE, so there is at most one outstanding request.
  - DROP: Imem_Req = 0. On Rvalid, discard the response and go to IDLE.
- Address: Imem_Addr = PC, combinational.
- Bubble: combinational, = !(Imem_Req & Imem_Gnt).
  - The PC advances only on an accepted request.
  - Throughput is one instruction per 2 cycles minimum with zero-wait memory (request cycle + response cycle). Rvalid in the cycle after Gnt is the fastest case.
- Credit rule: a request is issued only if count + 1 <= DEPTH, counting the outstanding entry. The queue therefore never overflows; a response always has a slot.
- Queue behaviour:
  - Head is registered out: ID_Valid = (count != 0); ID_Instr and ID_PC come from the head entry.
  - A pop occurs on ID_Valid & ID_Ready. ID_Ready while empty is ignored.
  - Simultaneous push and pop: count unchanged, and both pointers advance modulo DEPTH (wrap-around).
- Flush (priority over every other event in the same cycle):
  - count := 0 and pointers are reset.
  - No request is issued that cycle (Imem_Req = 0, Bubble = 1 so the redirect target is not skipped).
  - WAIT with Rvalid in the flush cycle: the response is dropped and the FSM goes to IDLE.
  - WAIT without Rvalid: go to DROP.
  - DROP stays DROP.
- Reset mid-operation: return to reset values immediately. Any later Rvalid from a request issued before reset is ignored, because the FSM is in IDLE.
- Rvalid received in IDLE is ignored and never written to the queue.

Optional Feature:
- Macro: IFETCH_PERF_CNT_EN.
- When defined:
  - Adds 32-bit saturating counters: fetched, flushed-dropped (queue entries plus in-flight), and stall_cycles (Bubble = 1 and not Flush).
  - Adds output ports Perf_Fetched, Perf_Dropped, Perf_Stall, each 32 bits.
  - All counters cleared by Reset.
- When undefined: the counters and ports are absent; all other behaviour is identical.

Decomposition:
- Shared pipeline package holds:
  - RESET_PC constant.
  - Fetch FSM state encoding (IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2).
  - Queue entry typedef {instr[31:0], pc[AW-1:0]}.
- One sub-module, ifq_fifo:
  - Parameterised DEPTH-entry synchronous FIFO with push, pop, clear, count and head outputs.
  - The FSM and Bubble logic stay in ifetch_queue.

Test Plan:
- Reset check: Reset = 1 for 2 cycles then released, ID_Ready = 0, Gnt = 0 -> ID_Valid = 0, ID_PC = 32'h3000, Bubble = 1, Imem_Req = 1 after release.
- Fill: zero-wait memory (Gnt = 1, Rvalid the cycle after Gnt), PC = 32'h3000 advancing by 4 on !Bubble, ID_Ready = 0 -> exactly 4 entries (32'h3000..32'h300C) queued, then Imem_Req = 0 and Bubble = 1 held indefinitely.
- Simultaneous push and pop: full queue, ID_Ready = 1 continuously -> in-order ID_PC sequence 3000, 3004, ... across pointer wrap; no lost or duplicated entry; count never exceeds 4.
- Flush in WAIT: request at 32'h3008 granted, Flush pulsed before Rvalid, PC := 32'h3100 -> stale response dropped via DROP; next ID_PC = 32'h3100; queue empty in the cycle after the flush.
- Flush in the Rvalid cycle: Flush and Rvalid coincide -> response discarded; FSM goes to IDLE; no request issued that cycle.
- Gnt stalls: Gnt low for 5 cycles -> Bubble = 1 for all 5; PC unchanged; first fetched ID_PC equals the held PC.
